// File: rtl/match_string_loader.sv
// Unpacks host config words into a shadow match string and commits it atomically to the comparator.
// Optional: define MATCH_STRING_CASE_FOLD_EN to fold ASCII uppercase to lowercase on load.
module match_string_loader #(
    parameter int unsigned MAX_LEN = 17,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [DATA_W-1:0]          cfg_data,
    input  logic                       cfg_last,
    input  logic [1:0]                 cfg_bytes,
    input  logic                       cfg_abort,
    output logic [8*MAX_LEN-1:0]       string_out,
    output logic [$clog2(MAX_LEN)-1:0] strlen_out,
    output logic                       str_valid,
    output logic                       cmp_clear,
    output logic                       err_overflow
);

    localparam int unsigned IDX_W = $clog2(MAX_LEN);
    localparam int unsigned PW    = IDX_W + 1;
    localparam int unsigned BPW   = DATA_W / 8;
    localparam logic [IDX_W-1:0] MAX_CNT = IDX_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} state_t;

    state_t                 state, next_state;
    logic [8*MAX_LEN-1:0]   shadow, shadow_wr;
    logic [IDX_W-1:0]       count, start, sum;
    logic [2:0]             n;
    logic [PW-1:0]          idx;
    logic                   accept, overflow, ovf_set, clear_shadow, load_shadow;

    function automatic logic [7:0] fold_byte(input logic [7:0] b);
`ifdef MATCH_STRING_CASE_FOLD_EN
        return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
`else
        return b;
`endif
    endfunction

    always_comb begin
        next_state   = state;
        cfg_ready    = n_rst && (state != COMMIT);
        accept       = cfg_valid && cfg_ready && !cfg_abort;
        n            = (cfg_last && cfg_bytes != 2'd0) ? {1'b0, cfg_bytes} : 3'd4;
        start        = (state == IDLE) ? '0 : count;
        sum          = start + IDX_W'(n);
        overflow     = sum > MAX_CNT;
        ovf_set      = 1'b0;
        shadow_wr    = (state == IDLE) ? '0 : shadow;
        idx          = '0;

        // Bytes landing past MAX_LEN are dropped; such a word always overflows anyway.
        for (int unsigned j = 0; j < BPW; j++) begin
            idx = {1'b0, start} + PW'(j);
            if (3'(j) < n && idx < PW'(MAX_LEN))
                shadow_wr[8*int'(idx) +: 8] = fold_byte(cfg_data[DATA_W-1-8*j -: 8]);
        end

        case (state)
            IDLE: begin
                if (accept) next_state = cfg_last ? COMMIT : LOAD;
            end
            LOAD: begin
                if (cfg_abort) begin
                    next_state = IDLE;
                end else if (accept) begin
                    if (overflow) begin
                        ovf_set    = 1'b1;
                        next_state = cfg_last ? IDLE : DRAIN;
                    end else begin
                        next_state = cfg_last ? COMMIT : LOAD;
                    end
                end
            end
            DRAIN: begin
                if (cfg_abort || (accept && cfg_last)) next_state = IDLE;
            end
            COMMIT: next_state = IDLE;
            default: next_state = IDLE;
        endcase

        clear_shadow = (cfg_abort && state != COMMIT) || ovf_set;
        load_shadow  = accept && (state == IDLE || (state == LOAD && !overflow));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shadow       <= '0;
            count        <= '0;
            string_out   <= '0;
            strlen_out   <= '0;
            str_valid    <= 1'b0;
            cmp_clear    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            cmp_clear    <= (state == COMMIT);
            err_overflow <= ovf_set;
            if (state == COMMIT) begin
                string_out <= shadow;
                strlen_out <= count - IDX_W'(1);
                str_valid  <= 1'b1;
            end
            if (clear_shadow) begin
                shadow <= '0;
                count  <= '0;
            end else if (load_shadow) begin
                shadow <= shadow_wr;
                count  <= sum;
            end
        end
    end

endmodule

// File: tb/tb_match_string_loader.sv
// Scoreboard bench for match_string_loader: expected commits/overflows are queued as strings are sent.
module tb_match_string_loader;

    localparam int unsigned MAX_LEN = 17;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [31:0]  cfg_data = '0;
    logic         cfg_last = 1'b0;
    logic [1:0]   cfg_bytes = '0;
    logic         cfg_abort = 1'b0;
    logic [135:0] string_out;
    logic [4:0]   strlen_out;
    logic         str_valid;
    logic         cmp_clear;
    logic         err_overflow;

    match_string_loader #(.MAX_LEN(MAX_LEN), .DATA_W(32)) dut (
        .clk(clk), .n_rst(n_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .cfg_bytes(cfg_bytes), .cfg_abort(cfg_abort),
        .string_out(string_out), .strlen_out(strlen_out), .str_valid(str_valid),
        .cmp_clear(cmp_clear), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef MATCH_STRING_CASE_FOLD_EN
        if (b >= 8'h41 && b <= 8'h5A) return b | 8'h20;
`endif
        return b;
    endfunction

    typedef struct {
        logic         ovf;
        logic [135:0] str;
        logic [4:0]   len;
    } evt_t;

    evt_t         sb[$];
    logic [135:0] act_str = '0;
    logic [4:0]   act_len = '0;
    logic         act_valid = 1'b0;
    logic         prev_clear = 1'b0;
    logic         prev_ovf = 1'b0;
    logic [7:0]   msg [32];

    // Active-output model: only a scoreboarded commit may change it.
    always @(negedge clk) begin
        evt_t e;
        if (n_rst) begin
            if (cmp_clear || err_overflow) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_evt", {cmp_clear, err_overflow}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    check_eq("evt_ovf", err_overflow, e.ovf);
                    check_eq("evt_clear", cmp_clear, !e.ovf);
                    if (!e.ovf) begin
                        act_str   = e.str;
                        act_len   = e.len;
                        act_valid = 1'b1;
                    end
                end
            end
            check_eq("clear_width", cmp_clear & prev_clear, 1'b0);
            check_eq("ovf_width", err_overflow & prev_ovf, 1'b0);
            check_eq("string_out", string_out, act_str);
            check_eq("strlen_out", strlen_out, act_len);
            check_eq("str_valid", str_valid, act_valid);
            prev_clear = cmp_clear;
            prev_ovf   = err_overflow;
        end else begin
            prev_clear = 1'b0;
            prev_ovf   = 1'b0;
        end
    end

    task automatic send_word(input logic [31:0] data, input logic last, input logic [1:0] nb,
                             input logic chk_ready);
        int g;
        cfg_data  = data;
        cfg_last  = last;
        cfg_bytes = nb;
        cfg_valid = 1'b1;
        if (chk_ready) check_eq("ready_hi", cfg_ready, 1'b1);
        g = 0;
        while (!cfg_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!cfg_ready) check_eq("ready_timeout", cfg_ready, 1'b1);
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic send_msg(input int unsigned len);
        evt_t         e;
        int unsigned  words;
        logic [31:0]  w;
        e.ovf = (len > MAX_LEN);
        e.str = '0;
        e.len = 5'(len - 1);
        for (int unsigned k = 0; k < len && k < MAX_LEN; k++) e.str[8*k +: 8] = fold(msg[k]);
        sb.push_back(e);
        words = (len + 3) / 4;
        for (int unsigned i = 0; i < words; i++) begin
            for (int unsigned j = 0; j < 4; j++)
                w[31-8*j -: 8] = (4*i + j < len) ? msg[4*i + j] : 8'($urandom);
            send_word(w, i == words - 1, 2'(len % 4), i != 0);
        end
        check_eq("ready_after_last", cfg_ready, e.ovf);
    endtask

    task automatic set_letters(input int unsigned len, input logic [7:0] first);
        for (int unsigned i = 0; i < len; i++) msg[i] = first + 8'(i);
    endtask

    task automatic set_word(input logic [31:0] v);
        msg[0] = v[31:24]; msg[1] = v[23:16]; msg[2] = v[15:8]; msg[3] = v[7:0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_string", string_out, '0);
        check_eq("rst_strlen", strlen_out, '0);
        check_eq("rst_valid", str_valid, 1'b0);
        check_eq("rst_clear", cmp_clear, 1'b0);
        check_eq("rst_ovf", err_overflow, 1'b0);
        check_eq("rst_ready", cfg_ready, 1'b0);
        n_rst = 1'b1;
        @(negedge clk);

        set_word(32'h6576696C);
        send_msg(4);
        repeat (3) @(negedge clk);
        check_eq("evil_len", strlen_out, 5'd3);
        check_eq("evil_str", string_out, 136'h6C69_7665);

        set_letters(17, 8'h41);
        send_msg(17);
        repeat (3) @(negedge clk);
        check_eq("full_len", strlen_out, 5'd16);
        check_eq("char16", string_out[135:128], fold(8'h51));

        set_word(32'h6576696C);
        send_msg(4);
        set_letters(18, 8'h61);
        send_msg(18);
        repeat (3) @(negedge clk);
        check_eq("ovf_keeps_len", strlen_out, 5'd3);

        set_letters(28, 8'h30);
        send_msg(28);
        msg[0] = 8'h41;
        send_msg(1);
        repeat (3) @(negedge clk);
        check_eq("one_byte_len", strlen_out, 5'd0);

        send_word(32'h11223344, 1'b0, 2'd0, 1'b0);
        send_word(32'h55667788, 1'b0, 2'd0, 1'b1);
        cfg_data  = 32'h99AABBCC;
        cfg_last  = 1'b1;
        cfg_valid = 1'b1;
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        repeat (3) @(negedge clk);
        msg[0] = 8'h78; msg[1] = 8'h79;
        send_msg(2);
        repeat (3) @(negedge clk);
        check_eq("post_abort_len", strlen_out, 5'd1);

        set_word(32'h4556494C);
        send_msg(4);
        repeat (3) @(negedge clk);
`ifdef MATCH_STRING_CASE_FOLD_EN
        check_eq("fold_str", string_out[31:0], 32'h6C69_7665);
`else
        check_eq("fold_str", string_out[31:0], 32'h4C49_5645);
`endif

        send_word(32'h41424344, 1'b0, 2'd0, 1'b0);
        send_word(32'h45464748, 1'b0, 2'd0, 1'b1);
        n_rst = 1'b0;
        #1;
        check_eq("mid_rst_string", string_out, '0);
        check_eq("mid_rst_valid", str_valid, 1'b0);
        check_eq("mid_rst_clear", cmp_clear, 1'b0);
        check_eq("mid_rst_ready", cfg_ready, 1'b0);
        act_str   = '0;
        act_len   = '0;
        act_valid = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        msg[0] = 8'h78; msg[1] = 8'h79; msg[2] = 8'h7A;
        send_msg(3);
        repeat (3) @(negedge clk);
        check_eq("fresh_len", strlen_out, 5'd2);

        repeat (5) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/match_string_loader.md
Name: match_string_loader

Overview:
- Configuration-side writer for the sniffer's match-string comparators.
- Accepts a corrupt/match string from the Atom host as a stream of 32-bit words.
- Unpacks the words into a shadow byte buffer, then atomically commits it to the active string and length outputs that drive a comparator.
- Pulses the comparator clear on every commit, so no stale match survives a string change.

Parameters:
- MAX_LEN, 17, maximum string length in bytes (index width = 5 bits).
- DATA_W, 32, host word width; fixed at 32 (4 bytes/word).

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  host word valid
- cfg_ready  out  1  loader can accept word
- cfg_data  in  32  string bytes; first char in [31:24], then [23:16], [15:8], [7:0]
- cfg_last  in  1  final word of string
- cfg_bytes  in  2  valid bytes in last word (0=4, 1..3); ignored when cfg_last=0
- cfg_abort  in  1  discard partially loaded string
- string_out  out  8*MAX_LEN  active string; char k at [8k+7:8k]; bytes >= length are 0x00
- strlen_out  out  5  index of last valid char (length-1)
- str_valid  out  1  an active string has been committed since reset
- cmp_clear  out  1  one-cycle registered pulse to comparator clear
- err_overflow  out  1  one-cycle pulse: string exceeded MAX_LEN, discarded

Behaviour:
- Reset values: string_out=0, strlen_out=0, str_valid=0, cmp_clear=0, err_overflow=0, cfg_ready=0 while n_rst low. Internal state: FSM=IDLE, byte count=0, shadow=0.
- Word accepted on a rising edge with cfg_valid & cfg_ready & !cfg_abort.
- FSM states:
  - IDLE: cfg_ready=1. Accept -> clear shadow, write bytes at index 0..n-1, count=n.
    - Non-last word -> LOAD.
    - Last word -> COMMIT.
  - LOAD: cfg_ready=1. Accept writes bytes at shadow[count..count+n-1], count+=n. Transitions:
    - count+n > MAX_LEN -> DRAIN, with err_overflow pulse the next cycle. If that word was last -> IDLE with the pulse instead.
    - Otherwise, last -> COMMIT; non-last -> stay in LOAD.
  - DRAIN: cfg_ready=1. Accepted words are discarded; accepted last word -> IDLE.
  - COMMIT: cfg_ready=0, exactly one cycle. At the closing edge:
    - string_out<=shadow, strlen_out<=count-1, str_valid<=1, cmp_clear<=1 (high for the next cycle only).
    - -> IDLE.
- Byte count n per word: 4 if cfg_last=0; otherwise 4 when cfg_bytes=0, else cfg_bytes.
- Latency: last word accepted at edge E. New string_out/strlen_out are visible after edge E+1; cmp_clear is high in the cycle after E+1.
- Overflow check uses a 5-bit sum (max 16+4=20, no wrap). MAX_LEN bytes is legal; MAX_LEN+1 is overflow.
- Active outputs change only in COMMIT. Overflow, abort and DRAIN never alter string_out, strlen_out or str_valid.
- cfg_abort (any state except COMMIT): word not accepted that cycle, shadow and count cleared, -> IDLE, no error pulse. In COMMIT, abort is ignored and the commit completes.
- cfg_abort with cfg_valid in the same cycle: abort wins, word dropped.
- Reset mid-load or mid-commit: all state returns to reset values; no cmp_clear is issued.

Optional Feature:
- Macro: MATCH_STRING_CASE_FOLD_EN.
- Defined: each byte in 0x41..0x5A is written to the shadow as byte|0x20 (lowercase); all other bytes are unchanged.
- Undefined: bytes are stored verbatim; no folding logic is present.

Test Plan:
- Single word 0x6576696C, last=1, bytes=0 -> after E+1: chars 0..3 = 65 76 69 6C, rest 0x00, strlen_out=3, str_valid=1, cmp_clear high one cycle.
- Five words, last bytes=1 (17 chars "ABCDEFGHIJKLMNOPQ"; fold off) -> strlen_out=16, char16=0x51, no err_overflow.
- Active string "evil" loaded, then 5 words with last bytes=2 (18 chars) -> err_overflow one pulse, string_out and strlen_out still "evil"/3, no cmp_clear, cfg_ready=1 throughout.
- Overflow on word 5 with cfg_last=0, then two more words, last on the second -> DRAIN discards both, returns to IDLE; a next 1-byte load 0x41xxxxxx, bytes=1 commits strlen_out=0.
- Two words loaded, cfg_abort with cfg_valid high -> word dropped, no commit, outputs unchanged. With MATCH_STRING_CASE_FOLD_EN, load 0x4556494C -> char bytes 65 76 69 6C.
- n_rst asserted during LOAD after a prior commit -> string_out=0, str_valid=0, cmp_clear=0 immediately. A fresh load after release commits normally.
